// File: rtl/branch_perf_monitor.sv
// Windowed branch/fetch statistics monitor fed by the core's debug outputs.
// Active counters snapshot into shadow registers every WINDOW counted cycles.
//
// state | meaning
// IDLE  | paused, nothing counts, counters and window position retained
// PRIME | one cycle after (re)enable: load prev_pc, count cyc/mispred/jumps only
// COUNT | full counting, one window position per enabled cycle
module branch_perf_monitor #(
  parameter int CNT_W  = 32,
  parameter int WINDOW = 1024,
  parameter int PC_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [PC_W-1:0]  debug_pc,
  input  logic             debug_misprediction,
  input  logic             debug_jump,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             snap_valid,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, COUNT = 2'd2} state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]  prev_pc;
  logic [CNT_W-1:0] cyc, pc_chg, mispred, jumps, backward, stall_run, max_stall, win;
  logic [CNT_W-1:0] cyc_n, pc_chg_n, mispred_n, jumps_n, backward_n, stall_run_n, max_stall_n;
  logic [CNT_W-1:0] sh_cyc, sh_pc_chg, sh_mispred, sh_jumps, sh_backward, sh_max_stall;
  logic [CNT_W-1:0] rd_mux;
  logic             count_en, snap, rd_fire, pc_same;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   state_nxt = enable ? COUNT : IDLE;
      COUNT:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // PRIME always counts its single cycle; COUNT pauses as soon as enable drops
  assign count_en = (state == PRIME) || ((state == COUNT) && enable);
  assign snap     = count_en && (win == CNT_W'(WINDOW - 1));
  assign rd_fire  = rd_req && !rd_ack;
  assign pc_same  = (debug_pc == prev_pc);

  always_comb begin
    cyc_n       = sat_inc(cyc, 1'b1);
    mispred_n   = sat_inc(mispred, debug_misprediction);
    jumps_n     = sat_inc(jumps, debug_jump);
    pc_chg_n    = pc_chg;
    backward_n  = backward;
    stall_run_n = stall_run;
    max_stall_n = max_stall;
    if (state == COUNT) begin
      pc_chg_n    = sat_inc(pc_chg, !pc_same);
      backward_n  = sat_inc(backward, debug_pc < prev_pc);
      stall_run_n = pc_same ? sat_inc(stall_run, 1'b1) : '0;
      max_stall_n = (stall_run_n > max_stall) ? stall_run_n : max_stall;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0:    rd_mux = sh_cyc;
      3'd1:    rd_mux = sh_pc_chg;
      3'd2:    rd_mux = sh_mispred;
      3'd3:    rd_mux = sh_jumps;
      3'd4:    rd_mux = sh_backward;
      3'd5:    rd_mux = sh_max_stall;
      3'd6:    rd_mux = win;
      default: rd_mux = CNT_W'({state, overrun, snap_valid});
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      // clear is synchronous by virtue of sitting behind the clock edge
      state        <= IDLE;
      prev_pc      <= '0;
      cyc          <= '0;
      pc_chg       <= '0;
      mispred      <= '0;
      jumps        <= '0;
      backward     <= '0;
      stall_run    <= '0;
      max_stall    <= '0;
      win          <= '0;
      sh_cyc       <= '0;
      sh_pc_chg    <= '0;
      sh_mispred   <= '0;
      sh_jumps     <= '0;
      sh_backward  <= '0;
      sh_max_stall <= '0;
      rd_ack       <= 1'b0;
      rd_data      <= '0;
      snap_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_ack <= rd_fire;
      if (rd_fire) rd_data <= rd_mux;
      if (count_en) prev_pc <= debug_pc;

      if (snap) begin
        sh_cyc       <= cyc_n;
        sh_pc_chg    <= pc_chg_n;
        sh_mispred   <= mispred_n;
        sh_jumps     <= jumps_n;
        sh_backward  <= backward_n;
        sh_max_stall <= max_stall_n;
        cyc          <= '0;
        pc_chg       <= '0;
        mispred      <= '0;
        jumps        <= '0;
        backward     <= '0;
        stall_run    <= '0;
        max_stall    <= '0;
        win          <= '0;
      end else if (count_en) begin
        cyc       <= cyc_n;
        pc_chg    <= pc_chg_n;
        mispred   <= mispred_n;
        jumps     <= jumps_n;
        backward  <= backward_n;
        stall_run <= stall_run_n;
        max_stall <= max_stall_n;
        win       <= win + CNT_W'(1);
      end

      // a sel0 read on the snapshot edge consumes the old snapshot, not the new one
      if (snap) snap_valid <= 1'b1;
      else if (rd_fire && rd_sel == 3'd0) snap_valid <= 1'b0;

      if (snap && snap_valid && !(rd_fire && rd_sel == 3'd0)) overrun <= 1'b1;
      else if (rd_fire && rd_sel == 3'd7) overrun <= 1'b0;
    end
  end

endmodule
